dual_display_scan: RTL and testbench
====================================

Name: dual_display_scan

Overview:
- Downstream consumer of the dual binary/BCD converter output. Captures the 6-bit converted value and its format flag on a load strobe.
- Time-multiplexes the value onto a 2-digit common-anode 7-segment display.
- Holds new data in a shadow register and commits it only at a scan-frame boundary, so a frame never shows half-old, half-new digits.
- Flags BCD values that are not valid.

Parameters:
- REFRESH_DIV, 50000, clk cycles per digit slot; must be >= 2; the prescaler width is ceil(log2(REFRESH_DIV)).
- BLANK_LZ, 1, 1 = blank the tens digit when it is 0; 0 = always show it.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- load  in  1  single-cycle strobe; captures data and mode into the shadow register.
- mode  in  1  format of data. 0 = BCD {tens[1:0],units[3:0]}, range 00-39. 1 = binary 0-63, shown as 2 hex digits. Wired to the converter select.
- data  in  6  value from the converter output.
- seg_n  out  7  segments, active-low, bit order {g,f,e,d,c,b,a}.
- dp_n  out  1  decimal point, active-low.
- an_n  out  2  digit enables, active-low. Bit 0 = units (right digit), bit 1 = tens.
- err  out  1  displayed value is invalid BCD.
- pending  out  1  shadow register holds an uncommitted value.

Behaviour:
- Reset (asynchronous, rst_n=0):
  - Prescaler = 0, digit select = 0.
  - Displayed value and mode = 0; shadow value and mode = 0.
  - pending = 0, err = 0.
  - an_n = 2'b10, seg_n = 7'h40 (digit "0"), dp_n = 1.
- All outputs are registered.
- Prescaler:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - tick = 1 when the count is REFRESH_DIV-1.
  - On tick, the digit select toggles.
- Load:
  - Shadow value <= {mode, data}; pending <= 1.
  - A later load before commit overwrites the shadow value; only the last value loaded is ever committed.
- Commit:
  - Occurs on a tick while digit select = 1, i.e. at the wrap to digit 0.
  - Displayed value <= shadow value (its contents before that edge); pending <= 0.
- load and commit in the same cycle:
  - The commit takes the old shadow contents.
  - The new load lands in the shadow register, and pending stays 1.
- Commit with pending = 0: the displayed value is unchanged.
- Digit decode (from the displayed value dv, displayed mode dm):
  - hi = {2'b00, dv[5:4]}, lo = dv[3:0].
  - Hex patterns: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10 A=08 b=03 C=46 d=21 E=06 F=0E.
  - Dash = 3F, blank = 7F.
- Invalid BCD (dm=0 and lo>9):
  - err = 1.
  - Units digit shows E (06), tens digit shows dash (3F).
  - Leading-zero blanking is suppressed.
  - Otherwise err = 0.
- Leading-zero blanking: if BLANK_LZ=1, err=0 and hi=0, the tens digit shows 7F.
- dp_n = 0 only while the units digit is enabled and dm = 1. It marks that the value is hex/binary.
- Output timing:
  - an_n, seg_n and dp_n change on the edge after tick, all together (no ghosting skew).
  - an_n = 2'b10 while digit 0 is selected, 2'b01 while digit 1 is selected.
- Latency: from load to visible is at most 2*REFRESH_DIV+1 cycles and at least 1 cycle.
- Reset asserted mid-frame or with pending = 1 discards all state; the display returns to the reset image.

Decomposition:
- Shared package, segment constants:
  - SEG_0..SEG_F, SEG_DASH=7'h3F, SEG_BLANK=7'h7F.
  - Mode encodings MODE_BCD=0, MODE_BIN=1.
- Sub-module seg7_hex_decode: combinational, 4-bit nibble to 7-bit active-low pattern, instantiated once on the muxed nibble.
- Prescaler, shadow/commit logic and scan registers stay in the top module.

Test Plan (REFRESH_DIV=4, BLANK_LZ=1):
- Reset, then hold idle 20 cycles -> an_n toggles every 4 cycles starting at 2'b10; seg_n=7'h40 on units, 7'h7F on tens; err=0, pending=0.
- load with mode=0, data=6'h25 -> pending=1 until the commit tick, then 0. Units shows 7'h12 (5), tens shows 7'h24 (2), dp_n=1, err=0.
- load with mode=1, data=6'h3A -> units shows 7'h08 (A) with dp_n=0, tens shows 7'h30 (3).
- load with mode=0, data=6'h0C -> err=1; units shows 7'h06, tens shows 7'h3F (not blanked). Then load mode=0, data=6'h07 -> err=0, tens shows 7'h7F.
- load data=6'h11 early in the frame, then load data=6'h22 in the exact commit cycle -> displays 11 this frame with pending=1, then displays 22 after the next frame with pending=0.
- load 6'h33, then drop rst_n while pending=1 -> all outputs return to their reset values immediately; 6'h33 is never displayed.

Source files
------------

// File: rtl/dual_display_scan_pkg.sv
// Shared constants and types for the two-digit 7-segment scan driver.
// Segment patterns are active-low, bit order {g,f,e,d,c,b,a}.
package dual_display_scan_pkg;

   localparam logic [6:0] SEG_0     = 7'h40;
   localparam logic [6:0] SEG_1     = 7'h79;
   localparam logic [6:0] SEG_2     = 7'h24;
   localparam logic [6:0] SEG_3     = 7'h30;
   localparam logic [6:0] SEG_4     = 7'h19;
   localparam logic [6:0] SEG_5     = 7'h12;
   localparam logic [6:0] SEG_6     = 7'h02;
   localparam logic [6:0] SEG_7     = 7'h78;
   localparam logic [6:0] SEG_8     = 7'h00;
   localparam logic [6:0] SEG_9     = 7'h10;
   localparam logic [6:0] SEG_A     = 7'h08;
   localparam logic [6:0] SEG_B     = 7'h03;
   localparam logic [6:0] SEG_C     = 7'h46;
   localparam logic [6:0] SEG_D     = 7'h21;
   localparam logic [6:0] SEG_E     = 7'h06;
   localparam logic [6:0] SEG_F     = 7'h0E;
   localparam logic [6:0] SEG_DASH  = 7'h3F;
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   localparam logic MODE_BCD = 1'b0;
   localparam logic MODE_BIN = 1'b1;

   typedef struct packed {
      logic       mode;
      logic [5:0] value;
   } disp_val_t;

   // BCD units nibble above 9 cannot come from a valid conversion.
   function automatic logic is_bad_bcd(input disp_val_t v);
      return (v.mode == MODE_BCD) && (v.value[3:0] > 4'd9);
   endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational nibble to active-low 7-segment pattern (0-9, A-F).
module seg7_hex_decode
   import dual_display_scan_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg_n
);

   always_comb begin
      seg_n = SEG_BLANK;
      case (nibble)
         4'h0: seg_n = SEG_0;
         4'h1: seg_n = SEG_1;
         4'h2: seg_n = SEG_2;
         4'h3: seg_n = SEG_3;
         4'h4: seg_n = SEG_4;
         4'h5: seg_n = SEG_5;
         4'h6: seg_n = SEG_6;
         4'h7: seg_n = SEG_7;
         4'h8: seg_n = SEG_8;
         4'h9: seg_n = SEG_9;
         4'hA: seg_n = SEG_A;
         4'hB: seg_n = SEG_B;
         4'hC: seg_n = SEG_C;
         4'hD: seg_n = SEG_D;
         4'hE: seg_n = SEG_E;
         4'hF: seg_n = SEG_F;
         default: seg_n = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/dual_display_scan.sv
// Two-digit common-anode scan driver with shadow register committed at frame boundaries.
// Outputs are computed from next-state values so anodes and segments switch on the same edge.
module dual_display_scan
   import dual_display_scan_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 50000,
   parameter bit          BLANK_LZ    = 1'b1
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic       mode,
   input  logic [5:0] data,
   output logic [6:0] seg_n,
   output logic       dp_n,
   output logic [1:0] an_n,
   output logic       err,
   output logic       pending
);

   localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

   logic [CntW-1:0] cnt_q, cnt_d;
   logic            sel_q, sel_d;
   disp_val_t       shadow_q, shadow_d;
   disp_val_t       disp_q, disp_d;
   logic            pending_q, pending_d;
   logic [6:0]      seg_n_q, seg_n_d;
   logic [1:0]      an_n_q, an_n_d;
   logic            dp_n_q, dp_n_d;
   logic            err_q, err_d;

   logic            tick;
   logic            commit;
   logic [3:0]      hi, lo, nibble;
   logic [6:0]      dec_seg_n;

   always_comb begin
      tick      = (cnt_q == CntMax);
      cnt_d     = tick ? '0 : cnt_q + 1'b1;
      sel_d     = sel_q ^ tick;
      commit    = tick & sel_q;
      // Commit sees the pre-edge shadow, so a same-cycle load waits for the next frame.
      disp_d    = (commit && pending_q) ? shadow_q : disp_q;
      shadow_d  = load ? disp_val_t'({mode, data}) : shadow_q;
      pending_d = load ? 1'b1 : (commit ? 1'b0 : pending_q);
   end

   always_comb begin
      hi     = {2'b00, disp_d.value[5:4]};
      lo     = disp_d.value[3:0];
      nibble = sel_d ? hi : lo;
      err_d  = is_bad_bcd(disp_d);

      seg_n_d = dec_seg_n;
      if (err_d) begin
         seg_n_d = sel_d ? SEG_DASH : SEG_E;
      end else if (sel_d && BLANK_LZ && (hi == 4'd0)) begin
         seg_n_d = SEG_BLANK;
      end

      an_n_d = sel_d ? 2'b01 : 2'b10;
      dp_n_d = !(!sel_d && (disp_d.mode == MODE_BIN));
   end

   seg7_hex_decode u_dec (
      .nibble (nibble),
      .seg_n  (dec_seg_n)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q     <= '0;
         sel_q     <= 1'b0;
         shadow_q  <= '0;
         disp_q    <= '0;
         pending_q <= 1'b0;
         seg_n_q   <= SEG_0;
         an_n_q    <= 2'b10;
         dp_n_q    <= 1'b1;
         err_q     <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         sel_q     <= sel_d;
         shadow_q  <= shadow_d;
         disp_q    <= disp_d;
         pending_q <= pending_d;
         seg_n_q   <= seg_n_d;
         an_n_q    <= an_n_d;
         dp_n_q    <= dp_n_d;
         err_q     <= err_d;
      end
   end

   assign seg_n   = seg_n_q;
   assign an_n    = an_n_q;
   assign dp_n    = dp_n_q;
   assign err     = err_q;
   assign pending = pending_q;

endmodule

// File: tb/tb_dual_display_scan.sv
// Directed bench for dual_display_scan with REFRESH_DIV=4, BLANK_LZ=1.
// cyc counts rising edges since reset release; frame phase is cyc % 8, commit edges at cyc % 8 == 0.
module tb_dual_display_scan;

   logic       clk;
   logic       rst_n;
   logic       load;
   logic       mode;
   logic [5:0] data;
   logic [6:0] seg_n;
   logic       dp_n;
   logic [1:0] an_n;
   logic       err;
   logic       pending;

   int total;
   int bad;
   int cyc;

   dual_display_scan #(
      .REFRESH_DIV (4),
      .BLANK_LZ    (1'b1)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .load    (load),
      .mode    (mode),
      .data    (data),
      .seg_n   (seg_n),
      .dp_n    (dp_n),
      .an_n    (an_n),
      .err     (err),
      .pending (pending)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;
   end

   // Advance to the falling edge at which cyc % 8 == k (at least one cycle).
   task automatic wait_to(input int k);
      @(negedge clk);
      while ((cyc % 8) != k) @(negedge clk);
   endtask

   // Load in the phase-1 window, then stop just after the commit edge.
   task automatic load_and_commit(input logic m, input logic [5:0] d);
      wait_to(1);
      load = 1'b1; mode = m; data = d;
      @(negedge clk);
      load = 1'b0;
      wait_to(0);
   endtask

   task automatic test_reset();
      logic [1:0] exp_an;
      logic [6:0] exp_seg;
      rst_n = 1'b0; load = 1'b0; mode = 1'b0; data = '0;
      repeat (2) @(negedge clk);
      total++;
      if (an_n !== 2'b10 || seg_n !== 7'h40 || dp_n !== 1'b1 || err !== 1'b0 || pending !== 1'b0) begin
         bad++;
         $display("FAIL reset_image: an_n=%b seg_n=%h dp_n=%b err=%b pending=%b want 10 40 1 0 0",
                  an_n, seg_n, dp_n, err, pending);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         exp_an  = (((cyc / 4) % 2) == 1) ? 2'b01 : 2'b10;
         exp_seg = (exp_an == 2'b01) ? 7'h7F : 7'h40;
         total++;
         if (an_n !== exp_an || seg_n !== exp_seg || dp_n !== 1'b1 || err !== 1'b0
             || pending !== 1'b0) begin
            bad++;
            $display("FAIL idle_scan cyc=%0d: an_n=%b seg_n=%h dp_n=%b err=%b pend=%b want %b %h 1 0 0",
                     cyc, an_n, seg_n, dp_n, err, pending, exp_an, exp_seg);
         end
      end
   endtask

   task automatic test_bcd_load();
      wait_to(1);
      load = 1'b1; mode = 1'b0; data = 6'h25;
      @(negedge clk);
      load = 1'b0;
      total++;
      if (pending !== 1'b1) begin
         bad++;
         $display("FAIL bcd_pending_set: pending=%b want 1", pending);
      end
      wait_to(7);
      total++;
      if (pending !== 1'b1 || an_n !== 2'b01 || seg_n !== 7'h7F) begin
         bad++;
         $display("FAIL bcd_before_commit: pending=%b an_n=%b seg_n=%h want 1 01 7f",
                  pending, an_n, seg_n);
      end
      @(negedge clk);
      total++;
      if (pending !== 1'b0 || an_n !== 2'b10 || seg_n !== 7'h12 || dp_n !== 1'b1 || err !== 1'b0) begin
         bad++;
         $display("FAIL bcd_units: pend=%b an_n=%b seg_n=%h dp_n=%b err=%b want 0 10 12 1 0",
                  pending, an_n, seg_n, dp_n, err);
      end
      repeat (4) @(negedge clk);
      total++;
      if (an_n !== 2'b01 || seg_n !== 7'h24 || dp_n !== 1'b1 || err !== 1'b0) begin
         bad++;
         $display("FAIL bcd_tens: an_n=%b seg_n=%h dp_n=%b err=%b want 01 24 1 0",
                  an_n, seg_n, dp_n, err);
      end
   endtask

   task automatic test_bin_load();
      load_and_commit(1'b1, 6'h3A);
      total++;
      if (an_n !== 2'b10 || seg_n !== 7'h08 || dp_n !== 1'b0 || err !== 1'b0) begin
         bad++;
         $display("FAIL bin_units: an_n=%b seg_n=%h dp_n=%b err=%b want 10 08 0 0",
                  an_n, seg_n, dp_n, err);
      end
      repeat (4) @(negedge clk);
      total++;
      if (an_n !== 2'b01 || seg_n !== 7'h30 || dp_n !== 1'b1) begin
         bad++;
         $display("FAIL bin_tens: an_n=%b seg_n=%h dp_n=%b want 01 30 1", an_n, seg_n, dp_n);
      end
   endtask

   task automatic test_invalid_bcd();
      load_and_commit(1'b0, 6'h0C);
      total++;
      if (err !== 1'b1 || seg_n !== 7'h06 || dp_n !== 1'b1) begin
         bad++;
         $display("FAIL bad_bcd_units: err=%b seg_n=%h dp_n=%b want 1 06 1", err, seg_n, dp_n);
      end
      repeat (4) @(negedge clk);
      total++;
      if (err !== 1'b1 || an_n !== 2'b01 || seg_n !== 7'h3F) begin
         bad++;
         $display("FAIL bad_bcd_tens: err=%b an_n=%b seg_n=%h want 1 01 3f", err, an_n, seg_n);
      end
      load_and_commit(1'b0, 6'h07);
      total++;
      if (err !== 1'b0 || seg_n !== 7'h78) begin
         bad++;
         $display("FAIL good_bcd_units: err=%b seg_n=%h want 0 78", err, seg_n);
      end
      repeat (4) @(negedge clk);
      total++;
      if (err !== 1'b0 || seg_n !== 7'h7F) begin
         bad++;
         $display("FAIL good_bcd_tens_blank: err=%b seg_n=%h want 0 7f", err, seg_n);
      end
   endtask

   task automatic test_back_to_back();
      wait_to(1);
      load = 1'b1; mode = 1'b0; data = 6'h11;
      @(negedge clk);
      load = 1'b0;
      wait_to(7);
      load = 1'b1; data = 6'h22;
      @(negedge clk);
      load = 1'b0;
      total++;
      if (seg_n !== 7'h79 || an_n !== 2'b10 || pending !== 1'b1) begin
         bad++;
         $display("FAIL b2b_first_units: seg_n=%h an_n=%b pending=%b want 79 10 1",
                  seg_n, an_n, pending);
      end
      repeat (4) @(negedge clk);
      total++;
      if (seg_n !== 7'h79 || an_n !== 2'b01 || pending !== 1'b1) begin
         bad++;
         $display("FAIL b2b_first_tens: seg_n=%h an_n=%b pending=%b want 79 01 1",
                  seg_n, an_n, pending);
      end
      wait_to(0);
      total++;
      if (seg_n !== 7'h24 || an_n !== 2'b10 || pending !== 1'b0) begin
         bad++;
         $display("FAIL b2b_second_units: seg_n=%h an_n=%b pending=%b want 24 10 0",
                  seg_n, an_n, pending);
      end
      repeat (4) @(negedge clk);
      total++;
      if (seg_n !== 7'h24 || an_n !== 2'b01) begin
         bad++;
         $display("FAIL b2b_second_tens: seg_n=%h an_n=%b want 24 01", seg_n, an_n);
      end
   endtask

   task automatic test_reset_pending();
      wait_to(1);
      load = 1'b1; mode = 1'b0; data = 6'h33;
      @(negedge clk);
      load = 1'b0;
      total++;
      if (pending !== 1'b1) begin
         bad++;
         $display("FAIL rst_pending_set: pending=%b want 1", pending);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (an_n !== 2'b10 || seg_n !== 7'h40 || dp_n !== 1'b1 || err !== 1'b0 || pending !== 1'b0) begin
         bad++;
         $display("FAIL async_reset: an_n=%b seg_n=%h dp_n=%b err=%b pending=%b want 10 40 1 0 0",
                  an_n, seg_n, dp_n, err, pending);
      end
      @(negedge clk);
      rst_n = 1'b1;
      wait_to(0);
      total++;
      if (seg_n !== 7'h40 || an_n !== 2'b10 || pending !== 1'b0) begin
         bad++;
         $display("FAIL rst_discard_units: seg_n=%h an_n=%b pending=%b want 40 10 0",
                  seg_n, an_n, pending);
      end
      repeat (4) @(negedge clk);
      total++;
      if (seg_n !== 7'h7F || an_n !== 2'b01) begin
         bad++;
         $display("FAIL rst_discard_tens: seg_n=%h an_n=%b want 7f 01", seg_n, an_n);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_bcd_load();
      test_bin_load();
      test_invalid_bcd();
      test_back_to_back();
      test_reset_pending();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
